// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame-checker FSM encoding and parity selectors.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/uart_parity_calc.sv
// Expected parity of a data word: XOR-reduce, inverted for odd parity.
// Latency: combinational.
// Backpressure: none.
module uart_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PARITY_TYPE = PARITY_EVEN
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    localparam logic ODD_SEL = (PARITY_TYPE == PARITY_ODD);

    assign parity = (^data) ^ ODD_SEL;

endmodule

// File: rtl/uart_frame_check.sv
// UART frame checker: assembles data bits from mid-bit samples, checks start/parity/stop.
// Latency: every status pulse one cycle after the qualifying bit_valid strobe.
// Backpressure: none; advances only on bit_valid, frame_start ignored while busy.
module uart_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int PARITY_EN     = 1,
    parameter int PARITY_TYPE   = PARITY_EVEN,
    parameter int STOP_BITS     = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     bit_valid,
    input  logic                     sampled_bit,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     strt_glitch,
    output logic                     par_err,
    output logic                     stp_err,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int                     BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [1:0]             LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    state_t                  state;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [1:0]              stop_cnt;
    logic                    stop_fail;
    logic                    par_fail;
    logic [DATA_WIDTH-1:0]   data_sh;
    logic                    parity_exp;
    logic                    last_stop_bad;
    logic                    err_hit;

    uart_parity_calc #(
        .WIDTH       (DATA_WIDTH),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_parity (
        .data   (data_sh),
        .parity (parity_exp)
    );

    // Stop failure as seen on the final stop strobe, including earlier stop bits.
    assign last_stop_bad = stop_fail | ~sampled_bit;

    always_comb begin
        err_hit = 1'b0;
        if (bit_valid) begin
            case (state)
                ST_START:  err_hit = sampled_bit;
                ST_PARITY: err_hit = (sampled_bit != parity_exp);
                ST_STOP:   err_hit = (stop_cnt == LAST_STOP) && last_stop_bad;
                default:   err_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            stop_cnt    <= '0;
            stop_fail   <= 1'b0;
            par_fail    <= 1'b0;
            data_sh     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            busy        <= 1'b0;
            err_count   <= '0;
        end else begin
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;

            if (err_hit && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_valid) begin
                        if (sampled_bit) begin
                            strt_glitch <= 1'b1;
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                        end else begin
                            state     <= ST_DATA;
                            bit_cnt   <= '0;
                            par_fail  <= 1'b0;
                            stop_fail <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        data_sh[bit_cnt] <= sampled_bit;
                        if (bit_cnt == LAST_BIT) begin
                            state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            stop_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        if (sampled_bit != parity_exp) begin
                            par_err  <= 1'b1;
                            par_fail <= 1'b1;
                        end
                        state    <= ST_STOP;
                        stop_cnt <= '0;
                    end
                end
                ST_STOP: begin
                    if (bit_valid) begin
                        if (stop_cnt == LAST_STOP) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            data_out   <= data_sh;
                            stp_err    <= last_stop_bad;
                            data_valid <= ~par_fail & ~last_stop_bad;
                            stop_fail  <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 2'd1;
                            if (!sampled_bit) begin
                                stop_fail <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_frame_check.md
UART_FRAME_CHECK -- requirements
Module: uart_frame_check

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-002 Parameter PARITY_EN, default 1, SHALL enable (1) or omit (0) the parity bit.
REQ-003 Parameter PARITY_TYPE, default 0, SHALL select even (0) or odd (1) parity.
REQ-004 Parameter STOP_BITS, default 1, SHALL set stop bits checked per frame; legal values 1, 2.
REQ-005 Parameter ERR_CNT_WIDTH, default 8, SHALL set the error counter width.
REQ-006 clk  in  1  SHALL be the single clock; all logic on posedge clk.
REQ-007 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-008 frame_start  in  1  SHALL be a one-cycle pulse from the start-edge detector.
REQ-009 bit_valid  in  1  SHALL be a one-cycle strobe marking sampled_bit valid (mid-bit sample).
REQ-010 sampled_bit  in  1  SHALL be the oversampled line value.
REQ-011 data_out  out  DATA_WIDTH  SHALL hold the last received data word, LSB first on the line.
REQ-012 data_valid  out  1  SHALL pulse one cycle for each error-free frame.
REQ-013 strt_glitch  out  1  SHALL pulse one cycle when the start bit samples 1.
REQ-014 par_err  out  1  SHALL pulse one cycle on a parity mismatch.
REQ-015 stp_err  out  1  SHALL pulse one cycle when any stop bit samples 0.
REQ-016 busy  out  1  SHALL be 1 in every state except IDLE.
REQ-017 err_count  out  ERR_CNT_WIDTH  SHALL count error events, saturating.

Function
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-019 IDLE->START on frame_start; bit_valid in IDLE SHALL be ignored; frame_start wins if both arrive together.
REQ-020 START on bit_valid: sampled_bit=1 -> strt_glitch=1 next cycle, go IDLE; sampled_bit=0 -> DATA, bit counter cleared to 0.
REQ-021 DATA SHALL shift sampled_bit into bit position counter on each bit_valid; after bit DATA_WIDTH-1 go PARITY if PARITY_EN else STOP.
REQ-022 PARITY on bit_valid: expected = XOR of data bits XOR PARITY_TYPE; mismatch -> par_err=1 next cycle; go STOP with stop counter 0.
REQ-023 STOP SHALL check each bit_valid for 1, accumulate a stop-fail flag, and after STOP_BITS strobes go IDLE.
REQ-024 On the final stop strobe, next cycle: data_out updated; stp_err=1 if stop-fail; data_valid=1 only if no parity and no stop failure in this frame.
REQ-025 Latency: every output pulse SHALL appear exactly one cycle after the qualifying bit_valid.
REQ-026 frame_start while busy SHALL be ignored; no abort or restart mid-frame.
REQ-027 data_out SHALL hold its value between frames and not change on a start glitch.
REQ-028 err_count SHALL increment by 1 on each strt_glitch, par_err or stp_err pulse, and hold at 2^ERR_CNT_WIDTH-1.
REQ-029 Cycles without bit_valid SHALL not advance state or counters.

Reset
REQ-030 rst=1 at any clk edge SHALL force IDLE, clear bit/stop counters and stop-fail flag, and zero all outputs including data_out and err_count, including mid-frame.
REQ-031 rst SHALL take priority over frame_start and bit_valid in the same cycle.

Structure
REQ-032 Shared package uart_rx_pkg SHALL hold the FSM state type and PARITY_EVEN/PARITY_ODD constants.
REQ-033 One sub-module, uart_parity_calc (parameterised XOR-reduce with type select), SHALL compute expected parity.

Verification
REQ-034 Default params, frame 0x55 even parity bit 0, stop 1 -> data_valid=1, data_out=0x55, no error pulses, err_count=0.
REQ-035 frame_start then start sample 1 -> strt_glitch one cycle, busy drops next cycle, data_out unchanged, err_count=1.
REQ-036 Frame 0xA3, parity bit 1 (wrong, even) -> par_err after parity strobe, data_valid=0, data_out=0xA3 at frame end.
REQ-037 STOP_BITS=2, second stop sampled 0 -> stp_err=1, data_valid=0; first stop 0 alone also -> stp_err=1.
REQ-038 ERR_CNT_WIDTH=2, five glitch frames -> err_count 1,2,3,3,3.
REQ-039 rst asserted after 4th data strobe -> IDLE, all outputs 0; following clean frame 0x0F -> data_valid=1, data_out=0x0F.
